// File: rtl/parking_pkg.sv
// Shared types and constants for the car-park gate sequencer and its neighbours.
// OCC_W and the default capacity must match the occupancy counter and the slot-LED chain.
package parking_pkg;

   localparam int OCC_W        = 8;
   localparam int CAPACITY_DEF = 20;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OPEN_IN  = 2'd1,
      OPEN_OUT = 2'd2,
      COOLDOWN = 2'd3
   } gate_state_e;

   typedef enum logic {
      SIDE_ENTRY = 1'b0,
      SIDE_EXIT  = 1'b1
   } side_e;

   // One timer serves both the open and the cooldown phase, so it is sized for the longer one.
   function automatic int timer_width(input int t, input int h);
      return $clog2(((t > h) ? t : h) + 1);
   endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter with a zero flag.
// A load takes priority; otherwise it counts down to zero and holds there.
module gate_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/parking_gate_sequencer.sv
// Entry/exit barrier sequencer: round-robin arbitration, one car per transaction,
// and inc/dec pulses to the occupancy counter only after a car has actually passed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | both gates closed, waiting for an eligible request
// OPEN_IN  | entry barrier open, waiting for car_passed or timeout
// OPEN_OUT | exit barrier open, waiting for car_passed or timeout
// COOLDOWN | both gates closed for HOLDOFF cycles before the next grant
module parking_gate_sequencer
   import parking_pkg::*;
#(
   parameter int CAPACITY = CAPACITY_DEF,
   parameter int TIMEOUT  = 16,
   parameter int HOLDOFF  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             car_passed,
   input  logic [OCC_W-1:0] occupancy,
   output logic             gate_in_open,
   output logic             gate_out_open,
   output logic             inc_pulse,
   output logic             dec_pulse,
   output logic             full,
   output logic             busy,
   output logic             timeout_err
);

   localparam int TW = timer_width(TIMEOUT, HOLDOFF);

   localparam logic [1:0] ST_IDLE     = IDLE;
   localparam logic [1:0] ST_OPEN_IN  = OPEN_IN;
   localparam logic [1:0] ST_OPEN_OUT = OPEN_OUT;
   localparam logic [1:0] ST_COOLDOWN = COOLDOWN;

   localparam logic [OCC_W-1:0] CAP     = OCC_W'(CAPACITY);
   localparam logic [TW-1:0]    OPEN_LD = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]    HOLD_LD = TW'(HOLDOFF - 1);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   side_e         last_served;
   side_e         served_nxt;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_zero;
   logic          inc_nxt;
   logic          dec_nxt;
   logic          to_nxt;
   logic          ent_ok;
   logic          ext_ok;

   assign ent_ok = entry_req && (occupancy < CAP);
   assign ext_ok = exit_req && (occupancy != '0);

   gate_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_nxt  = state;
      served_nxt = last_served;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      inc_nxt    = 1'b0;
      dec_nxt    = 1'b0;
      to_nxt     = 1'b0;
      case (state)
         ST_IDLE: begin
            // On a tie the side not served last time wins.
            if (ent_ok && (!ext_ok || last_served == SIDE_EXIT)) begin
               state_nxt  = ST_OPEN_IN;
               served_nxt = SIDE_ENTRY;
               tmr_load   = 1'b1;
               tmr_val    = OPEN_LD;
            end else if (ext_ok) begin
               state_nxt  = ST_OPEN_OUT;
               served_nxt = SIDE_EXIT;
               tmr_load   = 1'b1;
               tmr_val    = OPEN_LD;
            end
         end
         ST_OPEN_IN, ST_OPEN_OUT: begin
            // A pass on the final open cycle still counts the car.
            if (car_passed) begin
               state_nxt = ST_COOLDOWN;
               tmr_load  = 1'b1;
               tmr_val   = HOLD_LD;
               inc_nxt   = (state == ST_OPEN_IN);
               dec_nxt   = (state == ST_OPEN_OUT);
            end else if (tmr_zero) begin
               state_nxt = ST_COOLDOWN;
               tmr_load  = 1'b1;
               tmr_val   = HOLD_LD;
               to_nxt    = 1'b1;
            end
         end
         ST_COOLDOWN: begin
            if (tmr_zero) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         last_served <= SIDE_EXIT;
         inc_pulse   <= 1'b0;
         dec_pulse   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_served <= served_nxt;
         inc_pulse   <= inc_nxt;
         dec_pulse   <= dec_nxt;
         timeout_err <= to_nxt;
      end
   end

   assign gate_in_open  = (state == ST_OPEN_IN);
   assign gate_out_open = (state == ST_OPEN_OUT);
   assign busy          = (state != ST_IDLE);
   assign full          = (occupancy >= CAP);

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Transaction-level bench for parking_gate_sequencer: each transaction's grant, open
// length, pulses and cooldown are predicted from the arbitration and timing rules.
module tb_parking_gate_sequencer;

   localparam int CAPACITY = 20;
   localparam int TIMEOUT  = 16;
   localparam int HOLDOFF  = 4;

   logic       clk;
   logic       reset;
   logic       entry_req;
   logic       exit_req;
   logic       car_passed;
   logic [7:0] occupancy;
   logic       gate_in_open;
   logic       gate_out_open;
   logic       inc_pulse;
   logic       dec_pulse;
   logic       full;
   logic       busy;
   logic       timeout_err;

   int errors;
   int checks;
   int occ;        // model occupancy (the bench plays the counter)
   bit last_exit;  // model: exit side was served last

   parking_gate_sequencer #(
      .CAPACITY (CAPACITY),
      .TIMEOUT  (TIMEOUT),
      .HOLDOFF  (HOLDOFF)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .entry_req     (entry_req),
      .exit_req      (exit_req),
      .car_passed    (car_passed),
      .occupancy     (occupancy),
      .gate_in_open  (gate_in_open),
      .gate_out_open (gate_out_open),
      .inc_pulse     (inc_pulse),
      .dec_pulse     (dec_pulse),
      .full          (full),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One arbitration attempt starting from IDLE. pd = open cycle on which car_passed is
   // presented (values above TIMEOUT mean the car never passes). hold = cycles to watch
   // when no grant is expected.
   task automatic txn(input string tag, input bit er, input bit xr, input int pd, input int hold);
      bit ent_ok, ext_ok, go_in, go_out, passed;
      int exp_len, open_len, cd_len, n_inc, n_dec, n_to, overlap, cd_gate, opens, busy_n;
      for (int c = 0; c < 64 && busy === 1'b1; c++) step();
      car_passed = $urandom_range(0, 1);
      ent_ok = er && (occ < CAPACITY);
      ext_ok = xr && (occ != 0);
      go_in  = (ent_ok && ext_ok) ? last_exit : ent_ok;
      go_out = (ent_ok || ext_ok) && !go_in;
      occupancy = 8'(occ);
      entry_req = er;
      exit_req  = xr;
      #1;
      chk({tag, ":full"}, full, (occ >= CAPACITY) ? 1 : 0);
      if (!go_in && !go_out) begin
         opens = 0;
         busy_n = 0;
         for (int c = 0; c < hold; c++) begin
            step();
            if (gate_in_open === 1'b1 || gate_out_open === 1'b1) opens++;
            if (busy !== 1'b0) busy_n++;
         end
         entry_req = 1'b0;
         exit_req  = 1'b0;
         chk({tag, ":no_grant_opens"}, opens, 0);
         chk({tag, ":no_grant_busy"}, busy_n, 0);
         return;
      end
      step();
      // A request may drop while its gate is open; only pass or timeout closes it.
      entry_req = 1'b0;
      exit_req  = 1'b0;
      chk({tag, ":grant_in"}, gate_in_open, go_in);
      chk({tag, ":grant_out"}, gate_out_open, go_out);
      chk({tag, ":grant_busy"}, busy, 1);
      last_exit = go_out;
      passed  = (pd <= TIMEOUT);
      exp_len = passed ? pd : TIMEOUT;
      open_len = 0; n_inc = 0; n_dec = 0; n_to = 0; overlap = 0; cd_gate = 0;
      for (int c = 0; c < TIMEOUT + 8; c++) begin
         if (gate_in_open !== 1'b1 && gate_out_open !== 1'b1) break;
         if (gate_in_open === 1'b1 && gate_out_open === 1'b1) overlap++;
         n_inc += int'(inc_pulse === 1'b1);
         n_dec += int'(dec_pulse === 1'b1);
         n_to  += int'(timeout_err === 1'b1);
         open_len++;
         car_passed = (open_len == pd);
         step();
      end
      car_passed = $urandom_range(0, 1);
      cd_len = 0;
      for (int c = 0; c < HOLDOFF + 8; c++) begin
         if (busy !== 1'b1) break;
         if (gate_in_open !== 1'b0 || gate_out_open !== 1'b0) cd_gate++;
         n_inc += int'(inc_pulse === 1'b1);
         n_dec += int'(dec_pulse === 1'b1);
         n_to  += int'(timeout_err === 1'b1);
         cd_len++;
         step();
      end
      n_inc += int'(inc_pulse === 1'b1);
      n_dec += int'(dec_pulse === 1'b1);
      n_to  += int'(timeout_err === 1'b1);
      chk({tag, ":open_len"}, open_len, exp_len);
      chk({tag, ":overlap"}, overlap, 0);
      chk({tag, ":cooldown_len"}, cd_len, HOLDOFF);
      chk({tag, ":cooldown_gate"}, cd_gate, 0);
      chk({tag, ":inc_count"}, n_inc, (passed && go_in) ? 1 : 0);
      chk({tag, ":dec_count"}, n_dec, (passed && go_out) ? 1 : 0);
      chk({tag, ":timeout_count"}, n_to, passed ? 0 : 1);
      chk({tag, ":idle_after"}, busy, 0);
      if (passed && go_in) occ++;
      if (passed && go_out) occ--;
   endtask

   initial begin
      int opens;
      errors = 0;
      checks = 0;
      reset = 1'b1;
      entry_req = 1'b0;
      exit_req = 1'b0;
      car_passed = 1'b0;
      occupancy = 8'd0;
      occ = 0;
      last_exit = 1'b1;
      step();
      step();
      chk("rst:gate_in", gate_in_open, 0);
      chk("rst:gate_out", gate_out_open, 0);
      chk("rst:inc", inc_pulse, 0);
      chk("rst:dec", dec_pulse, 0);
      chk("rst:timeout", timeout_err, 0);
      chk("rst:busy", busy, 0);
      chk("rst:full", full, 0);
      reset = 1'b0;
      step();

      occ = 5;
      txn("single_entry", 1'b1, 1'b0, 3, 0);

      occ = 20;
      txn("full_refuse", 1'b1, 1'b0, 1, 50);
      txn("full_exit", 1'b1, 1'b1, 2, 0);

      occ = 10;
      txn("rr1_in", 1'b1, 1'b1, 2, 0);
      txn("rr2_out", 1'b1, 1'b1, 1, 0);
      txn("rr3_in", 1'b1, 1'b1, 5, 0);
      txn("rr4_out", 1'b1, 1'b1, 3, 0);

      occ = 19;
      txn("cap_minus1_entry", 1'b1, 1'b1, 1, 0);
      txn("at_cap_exit_only", 1'b1, 1'b1, 4, 0);

      occ = 3;
      txn("timeout", 1'b1, 1'b0, TIMEOUT + 5, 0);
      txn("pass_at_timeout", 1'b1, 1'b0, TIMEOUT, 0);

      occ = 0;
      txn("empty_exit", 1'b0, 1'b1, 1, 8);

      // Reset two cycles into an exit opening, with the car "passing" at that very edge.
      occ = 5;
      occupancy = 8'(occ);
      car_passed = 1'b0;
      exit_req = 1'b1;
      step();
      exit_req = 1'b0;
      chk("rst_mid:opened", gate_out_open, 1);
      step();
      reset = 1'b1;
      car_passed = 1'b1;
      step();
      chk("rst_mid:gate_out", gate_out_open, 0);
      chk("rst_mid:dec", dec_pulse, 0);
      chk("rst_mid:timeout", timeout_err, 0);
      chk("rst_mid:busy", busy, 0);
      reset = 1'b0;
      car_passed = 1'b0;
      last_exit = 1'b1;
      occ = 0;
      occupancy = 8'd0;
      exit_req = 1'b1;
      opens = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (gate_out_open !== 1'b0 || busy !== 1'b0) opens++;
      end
      exit_req = 1'b0;
      chk("rst_mid:empty_no_grant", opens, 0);

      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 0) begin
            case ($urandom_range(0, 4))
               0: occ = 0;
               1: occ = CAPACITY;
               2: occ = CAPACITY - 1;
               default: occ = $urandom_range(0, CAPACITY);
            endcase
         end
         txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(1, TIMEOUT + 3), 6);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
